// File: rtl/sal_axi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sal_axi_pkg: AXI response codes, default widths and read-burst metadata   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package sal_axi_pkg;

   localparam int SAL_AXI_ID_WIDTH   = 4;
   localparam int SAL_AXI_DATA_WIDTH = 128;
   localparam int SAL_AXI_LEN_WIDTH  = 4;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef struct packed {
      logic [SAL_AXI_ID_WIDTH-1:0]  id;
      logic [SAL_AXI_LEN_WIDTH-1:0] len;
   } rd_meta_t;

endpackage
`default_nettype wire

// File: rtl/sal_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sal_sync_fifo: registered-storage FIFO, wrap-bit pointers, no bypass      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sal_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int             PW      = $clog2(DEPTH);
   localparam logic [PW:0]    PTR_ONE = (PW+1)'(1);

   logic [PW:0]      wptr_q;
   logic [PW:0]      rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   // Head reads as zero when empty so downstream outputs are clean after reset.
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q[PW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + PTR_ONE;
         if (pop_ok)  rptr_q <= rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[PW-1:0]] <= wdata_i;
   end

endmodule
`default_nettype wire

// File: rtl/sal_rd_resp_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sal_rd_resp_buf: reserves space per read burst, buffers DFI read beats   |
// | and replays them on the AXI R channel with rid/rlast. Revision: 1.0       |
// +--------------------------------------------------------------------------+
module sal_rd_resp_buf
   import sal_axi_pkg::*;
#(
   parameter int ID_WIDTH   = SAL_AXI_ID_WIDTH,
   parameter int DATA_WIDTH = SAL_AXI_DATA_WIDTH,
   parameter int LEN_WIDTH  = SAL_AXI_LEN_WIDTH,
   parameter int META_DEPTH = 8,
   parameter int DATA_DEPTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [ID_WIDTH-1:0]           req_id,
   input  logic [LEN_WIDTH-1:0]          req_len,
   input  logic                          rd_valid,
   input  logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rvalid,
   input  logic                          rready,
   output logic [ID_WIDTH-1:0]           rid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic [1:0]                    rresp,
   output logic                          rlast,
   output logic [$clog2(DATA_DEPTH):0]   free_beats,
   output logic                          err_unexpected
);

   localparam int                CNT_W     = $clog2(DATA_DEPTH) + 1;
   localparam int                META_W    = ID_WIDTH + LEN_WIDTH;
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DATA_DEPTH);
   localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
   localparam logic [LEN_WIDTH-1:0] ONE_LEN = LEN_WIDTH'(1);

   logic [CNT_W-1:0]     reserved_q, reserved_d;
   logic [CNT_W-1:0]     outstanding_q, outstanding_d;
   logic [CNT_W-1:0]     free_q;
   logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic                 err_q, err_d;

   logic [META_W-1:0]    meta_head;
   logic                 meta_full, meta_empty;
   logic                 data_full, data_empty;
   logic [CNT_W-1:0]     burst_beats;
   logic                 accept, rd_push, r_pop, meta_pop;
   logic [LEN_WIDTH-1:0] head_len;

   assign burst_beats = CNT_W'(req_len) + ONE_CNT;
   // One extra bit on the sum so reserved + len + 1 cannot wrap before the compare.
   assign req_ready   = !meta_full &&
                        (({1'b0, reserved_q} + {1'b0, burst_beats}) <= {1'b0, DEPTH_CNT});
   assign accept      = req_valid && req_ready;
   assign rd_push     = rd_valid && (outstanding_q != '0) && !data_full;
   assign r_pop       = rvalid && rready;
   assign meta_pop    = r_pop && rlast;

   assign head_len    = meta_head[LEN_WIDTH-1:0];
   assign rid         = meta_head[META_W-1:LEN_WIDTH];
   assign rvalid      = !data_empty;
   assign rlast       = !data_empty && !meta_empty && (beat_cnt_q == head_len);
   assign rresp       = RESP_OKAY;
   assign free_beats  = free_q;
   assign err_unexpected = err_q;

   always_comb begin
      reserved_d    = reserved_q;
      outstanding_d = outstanding_q;
      beat_cnt_d    = beat_cnt_q;
      err_d         = err_q;
      if (accept) begin
         reserved_d    = reserved_d + burst_beats;
         outstanding_d = outstanding_d + burst_beats;
      end
      if (r_pop) begin
         reserved_d = reserved_d - ONE_CNT;
         beat_cnt_d = rlast ? '0 : beat_cnt_q + ONE_LEN;
      end
      if (rd_push) outstanding_d = outstanding_d - ONE_CNT;
      if (rd_valid && (outstanding_q == '0)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reserved_q    <= '0;
         outstanding_q <= '0;
         beat_cnt_q    <= '0;
         err_q         <= 1'b0;
         free_q        <= DEPTH_CNT;
      end else begin
         reserved_q    <= reserved_d;
         outstanding_q <= outstanding_d;
         beat_cnt_q    <= beat_cnt_d;
         err_q         <= err_d;
         free_q        <= DEPTH_CNT - reserved_d;
      end
   end

   sal_sync_fifo #(
      .WIDTH (META_W),
      .DEPTH (META_DEPTH)
   ) u_meta_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .pop_i   (meta_pop),
      .wdata_i ({req_id, req_len}),
      .rdata_o (meta_head),
      .full_o  (meta_full),
      .empty_o (meta_empty)
   );

   sal_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DATA_DEPTH)
   ) u_data_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rd_push),
      .pop_i   (r_pop),
      .wdata_i (rd_data),
      .rdata_o (rdata),
      .full_o  (data_full),
      .empty_o (data_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_sal_rd_resp_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sal_rd_resp_buf: scoreboard bench for the read-response buffer         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sal_rd_resp_buf;

   localparam int ID_W   = 4;
   localparam int DATA_W = 128;
   localparam int LEN_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [ID_W-1:0]   req_id = '0;
   logic [LEN_W-1:0]  req_len = '0;
   logic              rd_valid = 1'b0;
   logic [DATA_W-1:0] rd_data = '0;
   logic              rvalid;
   logic              rready = 1'b1;
   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [5:0]        free_beats;
   logic              err_unexpected;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sal_rd_resp_buf #(
      .ID_WIDTH   (ID_W),
      .DATA_WIDTH (DATA_W),
      .LEN_WIDTH  (LEN_W),
      .META_DEPTH (8),
      .DATA_DEPTH (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_id         (req_id),
      .req_len        (req_len),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .rvalid         (rvalid),
      .rready         (rready),
      .rid            (rid),
      .rdata          (rdata),
      .rresp          (rresp),
      .rlast          (rlast),
      .free_beats     (free_beats),
      .err_unexpected (err_unexpected)
   );

   // R-channel scoreboard: every accepted beat must match the oldest expected beat.
   always @(negedge clk) begin
      if (!rst && rvalid && rready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL r_beat_extra: got id=%0h data=%0h last=%0b, expected no beat", rid, rdata, rlast);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({rid, rdata, rlast, rresp} !== {e.id, e.data, e.last, 2'b00}) begin
               errors++;
               $display("FAIL r_beat: got id=%0h data=%0h last=%0b resp=%0d, expected id=%0h data=%0h last=%0b resp=0",
                        rid, rdata, rlast, rresp, e.id, e.data, e.last);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({rvalid, rlast, rid, rdata, rresp, err_unexpected} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rvalid=%0b rlast=%0b rid=%0h rdata=%0h rresp=%0d err=%0b, expected all 0",
                  rvalid, rlast, rid, rdata, rresp, err_unexpected);
      end
      checks++;
      if (free_beats !== 6'd32 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_credit: got free_beats=%0d req_ready=%0b, expected 32 and 1", free_beats, req_ready);
      end
   endtask

   task automatic test_single_burst();
      rready = 1'b1;
      req_valid = 1'b1; req_id = 4'd3; req_len = 4'd3;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_req_ready: got %0b, expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd_valid = 1'b1;
         rd_data  = DATA_W'(8'hA0 + i);
         sb.push_back('{id: 4'd3, data: DATA_W'(8'hA0 + i), last: (i == 3)});
         tick();
         checks++;
         if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency beat %0d: got rvalid=%0b, expected 1", i, rvalid);
         end
      end
      rd_valid = 1'b0;
      tick(); tick();
      checks++;
      if (free_beats !== 6'd32 || rvalid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL single_done: got free_beats=%0d rvalid=%0b pending=%0d, expected 32 0 0",
                  free_beats, rvalid, sb.size());
      end
   endtask

   task automatic test_backpressure();
      rready = 1'b0;
      req_valid = 1'b1; req_id = 4'd1; req_len = 4'd1;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_valid = 1'b1;
         rd_data  = DATA_W'(8'hB0 + i);
         sb.push_back('{id: 4'd1, data: DATA_W'(8'hB0 + i), last: (i == 1)});
         tick();
      end
      rd_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({rvalid, rid, rdata, rlast} !== {1'b1, 4'd1, DATA_W'(8'hB0), 1'b0}) begin
            errors++;
            $display("FAIL stall_hold cycle %0d: got rvalid=%0b rid=%0h rdata=%0h rlast=%0b, expected 1 1 b0 0",
                     c, rvalid, rid, rdata, rlast);
         end
      end
      rready = 1'b1;
      for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
      tick();
      checks++;
      if (sb.size() != 0 || free_beats !== 6'd32) begin
         errors++;
         $display("FAIL stall_drain: got pending=%0d free_beats=%0d, expected 0 32", sb.size(), free_beats);
      end
   endtask

   task automatic test_reservation_full();
      rready = 1'b0;
      req_valid = 1'b1; req_id = 4'd2; req_len = 4'd15;
      for (int r = 0; r < 2; r++) begin
         checks++;
         if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resv_accept %0d: got req_ready=%0b, expected 1", r, req_ready);
         end
         tick();
      end
      req_valid = 1'b0;
      checks++;
      if (free_beats !== 6'd0) begin
         errors++;
         $display("FAIL resv_free: got free_beats=%0d, expected 0", free_beats);
      end
      for (int i = 0; i < 32; i++) begin
         rd_valid = 1'b1;
         rd_data  = DATA_W'(16'hC000 + i);
         sb.push_back('{id: 4'd2, data: DATA_W'(16'hC000 + i), last: ((i % 16) == 15)});
         tick();
      end
      rd_valid = 1'b0;
      req_valid = 1'b1; req_id = 4'd5; req_len = 4'd0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL resv_block cycle %0d: got req_ready=%0b, expected 0", c, req_ready);
         end
         tick();
      end
      rready = 1'b1;
      tick();
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL resv_release: got req_ready=%0b, expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 60 && sb.size() != 0; k++) tick();
      rd_valid = 1'b1;
      rd_data  = DATA_W'(16'hC5C5);
      sb.push_back('{id: 4'd5, data: DATA_W'(16'hC5C5), last: 1'b1});
      tick();
      rd_valid = 1'b0;
      for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
      tick();
      checks++;
      if (sb.size() != 0 || free_beats !== 6'd32 || err_unexpected !== 1'b0) begin
         errors++;
         $display("FAIL resv_drain: got pending=%0d free_beats=%0d err=%0b, expected 0 32 0",
                  sb.size(), free_beats, err_unexpected);
      end
   endtask

   task automatic test_meta_full();
      logic [ID_W-1:0] ids [8];
      rready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1; req_id = ID_W'(i); req_len = 4'd0;
         checks++;
         if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL meta_accept %0d: got req_ready=%0b, expected 1", i, req_ready);
         end
         tick();
      end
      req_id = 4'd9;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL meta_full: got req_ready=%0b, expected 0", req_ready);
      end
      rd_valid = 1'b1;
      rd_data  = DATA_W'(16'hD000);
      sb.push_back('{id: 4'd0, data: DATA_W'(16'hD000), last: 1'b1});
      tick();
      rd_valid = 1'b0;
      rready = 1'b1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL meta_no_same_cycle_credit: got req_ready=%0b, expected 0", req_ready);
      end
      tick();
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL meta_credit: got req_ready=%0b, expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) ids[i] = ID_W'(i + 1);
      ids[7] = 4'd9;
      for (int i = 0; i < 8; i++) begin
         rd_valid = 1'b1;
         rd_data  = DATA_W'(16'hD100 + i);
         sb.push_back('{id: ids[i], data: DATA_W'(16'hD100 + i), last: 1'b1});
         tick();
      end
      rd_valid = 1'b0;
      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      tick();
      checks++;
      if (sb.size() != 0 || free_beats !== 6'd32) begin
         errors++;
         $display("FAIL meta_drain: got pending=%0d free_beats=%0d, expected 0 32", sb.size(), free_beats);
      end
   endtask

   task automatic test_back_to_back();
      logic [ID_W-1:0]  rq_id  [3];
      logic [LEN_W-1:0] rq_len [3];
      int               beat;
      rq_id[0] = 4'hA; rq_len[0] = 4'd2;
      rq_id[1] = 4'hB; rq_len[1] = 4'd0;
      rq_id[2] = 4'hC; rq_len[2] = 4'd4;
      beat = 0;
      for (int b = 0; b < 3; b++)
         for (int j = 0; j <= int'(rq_len[b]); j++) begin
            sb.push_back('{id: rq_id[b], data: DATA_W'(32'hE0000 + beat), last: (j == int'(rq_len[b]))});
            beat++;
         end
      for (int i = 0; i < 11; i++) begin
         req_valid = (i < 3);
         if (i < 3) begin
            req_id = rq_id[i]; req_len = rq_len[i];
            checks++;
            if (req_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_accept %0d: got req_ready=%0b, expected 1", i, req_ready);
            end
         end
         rd_valid = (i >= 1 && i <= 9);
         rd_data  = DATA_W'(32'hE0000 + i - 1);
         rready   = 1'($urandom_range(0, 1));
         tick();
      end
      req_valid = 1'b0;
      rd_valid  = 1'b0;
      rready    = 1'b1;
      for (int k = 0; k < 30 && sb.size() != 0; k++) tick();
      tick();
      checks++;
      if (sb.size() != 0 || free_beats !== 6'd32 || err_unexpected !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got pending=%0d free_beats=%0d err=%0b, expected 0 32 0",
                  sb.size(), free_beats, err_unexpected);
      end
   endtask

   task automatic test_unexpected();
      rd_valid = 1'b1;
      rd_data  = DATA_W'(8'hEE);
      tick();
      rd_valid = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || err_unexpected !== 1'b1) begin
         errors++;
         $display("FAIL unexp_flag: got rvalid=%0b err=%0b, expected 0 1", rvalid, err_unexpected);
      end
      repeat (3) tick();
      checks++;
      if (rvalid !== 1'b0 || err_unexpected !== 1'b1 || free_beats !== 6'd32) begin
         errors++;
         $display("FAIL unexp_sticky: got rvalid=%0b err=%0b free_beats=%0d, expected 0 1 32",
                  rvalid, err_unexpected, free_beats);
      end
   endtask

   task automatic test_reset_mid_burst();
      rready = 1'b1;
      req_valid = 1'b1; req_id = 4'd6; req_len = 4'd3;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_valid = 1'b1;
         rd_data  = DATA_W'(8'hF0 + i);
         sb.push_back('{id: 4'd6, data: DATA_W'(8'hF0 + i), last: 1'b0});
         tick();
      end
      rd_data = DATA_W'(8'hF2);
      rst = 1'b1;
      tick();
      sb.delete();
      rst = 1'b0;
      rd_valid = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || free_beats !== 6'd32 || err_unexpected !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid: got rvalid=%0b free_beats=%0d err=%0b req_ready=%0b, expected 0 32 0 1",
                  rvalid, free_beats, err_unexpected, req_ready);
      end
      repeat (3) tick();
      checks++;
      if (rvalid !== 1'b0 || rlast !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_quiet: got rvalid=%0b rlast=%0b, expected 0 0", rvalid, rlast);
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_backpressure();
      test_reservation_full();
      test_meta_full();
      test_back_to_back();
      test_unexpected();
      test_reset_mid_burst();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d pending beats, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
